// File: rtl/aes_bridge_pkg.sv
// Shared register map, control/status bit positions and the IFIFO entry layout
// for the AES bus bridge.
package aes_bridge_pkg;

  localparam int unsigned BLOCK_W = 128;

  // Write-slave offsets
  localparam logic [3:0] ADDR_PTEXT  = 4'h0;
  localparam logic [3:0] ADDR_KEY    = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  // Read-slave offsets
  localparam logic [3:0] ADDR_CIPHER = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_BLKCNT = 4'hC;

  localparam int unsigned CTRL_CLEAR  = 0;
  localparam int unsigned CTRL_WHITEN = 1;
  localparam int unsigned CTRL_SWAP   = 2;

  localparam int unsigned ST_AVAIL    = 0;
  localparam int unsigned ST_IFULL    = 1;
  localparam int unsigned ST_PBUSY    = 2;
  localparam int unsigned ST_KBUSY    = 3;
  localparam int unsigned ST_ICNT_LSB = 8;
  localparam int unsigned ST_OCNT_LSB = 16;
  localparam int unsigned ST_CNT_W    = 8;

  localparam logic [BLOCK_W-1:0] RESET_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  // One IFIFO entry: whitened text with the key it was whitened under
  typedef struct packed {
    logic [BLOCK_W-1:0] text;
    logic [BLOCK_W-1:0] key;
  } core_blk_t;

endpackage

// File: rtl/aes_bus_bridge_if.sv
// Write slave, read slave and pipeline streams of the AES bus bridge.
interface aes_bus_bridge_if #(parameter int unsigned DATA_W = 32);
  import aes_bridge_pkg::*;

  logic              chipselect;
  logic [3:0]        address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;

  logic              chipselect1;
  logic [3:0]        address1;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest1;

  logic               core_valid;
  logic               core_ready;
  logic [BLOCK_W-1:0] core_text;
  logic [BLOCK_W-1:0] core_key;

  logic               res_valid;
  logic               res_ready;
  logic [BLOCK_W-1:0] res_text;

  modport slave (
    input  chipselect, address, write, writedata,
    output waitrequest,
    input  chipselect1, address1, read,
    output readdata, waitrequest1,
    output core_valid, core_text, core_key,
    input  core_ready,
    input  res_valid, res_text,
    output res_ready
  );

  modport master (
    output chipselect, address, write, writedata,
    input  waitrequest,
    output chipselect1, address1, read,
    input  readdata, waitrequest1,
    input  core_valid, core_text, core_key,
    output core_ready,
    output res_valid, res_text,
    input  res_ready
  );

endinterface

// File: rtl/aes_bridge_fifo.sv
// Synchronous FIFO with occupancy count; flags come from the registered count,
// so a push while full is refused even when a pop happens in the same cycle.
module aes_bridge_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage is not reset; pointers alone define validity
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/aes_bus_bridge.sv
// Bus front end for the AES round pipeline: packs plaintext/key beats, whitens
// blocks into the IFIFO, and unpacks returned ciphertext from the OFIFO.
module aes_bus_bridge
  import aes_bridge_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IFIFO_DEPTH = 4,
  parameter int unsigned OFIFO_DEPTH = 4
) (
  input logic        clock,
  input logic        reset,
  aes_bus_bridge_if.slave bus
);

  localparam int unsigned N      = BLOCK_W / DATA_W;
  localparam int unsigned BEAT_W = $clog2(N);
  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned ICNT_W = $clog2(IFIFO_DEPTH) + 1;
  localparam int unsigned OCNT_W = $clog2(OFIFO_DEPTH) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

  function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NBYTES; i++) r[8*i +: 8] = d[8*(NBYTES-1-i) +: 8];
    return r;
  endfunction

  logic [BEAT_W-1:0]  pbeat, kbeat, cbeat;
  logic [BLOCK_W-1:0] pt_buf, key_shadow, key_active, pt_asm, key_asm;
  logic               whiten, byte_swap;
  logic [31:0]        blk_cnt;

  logic               pt_wr, key_wr, ctl_wr, soft_clr, stall, pt_acc, pt_last;
  logic               c_rd, c_acc, c_last;
  logic [DATA_W-1:0]  wbeat, cslice;
  logic [31:0]        status;

  core_blk_t          ififo_din, ififo_dout;
  logic [BLOCK_W-1:0] ofifo_dout;
  logic [ICNT_W-1:0]  ififo_count;
  logic [OCNT_W-1:0]  ofifo_count;
  logic               ififo_full, ififo_empty, ofifo_full, ofifo_empty;

  // Write-side decode
  assign pt_wr    = bus.chipselect & bus.write & (bus.address == ADDR_PTEXT);
  assign key_wr   = bus.chipselect & bus.write & (bus.address == ADDR_KEY);
  assign ctl_wr   = bus.chipselect & bus.write & (bus.address == ADDR_CTRL);
  assign soft_clr = ctl_wr & bus.writedata[CTRL_CLEAR];
  assign pt_last  = (pbeat == LAST_BEAT);
  assign stall    = pt_wr & pt_last & ififo_full;
  assign pt_acc   = pt_wr & ~stall;
  assign wbeat    = byte_swap ? bswap(bus.writedata) : bus.writedata;

  assign bus.waitrequest = stall;

  // Drop the incoming beat into its MSB-first slot
  always_comb begin
    pt_asm  = pt_buf;
    key_asm = key_shadow;
    for (int i = 0; i < N; i++) begin
      if (pbeat == BEAT_W'(i)) pt_asm[BLOCK_W-DATA_W*(i+1) +: DATA_W] = wbeat;
      if (kbeat == BEAT_W'(i)) key_asm[BLOCK_W-DATA_W*(i+1) +: DATA_W] = wbeat;
    end
  end

  // key_active here is the pre-edge value, so a same-cycle key completion is not seen
  always_comb begin
    ififo_din.text = pt_asm ^ (whiten ? key_active : '0);
    ififo_din.key  = key_active;
  end

  // Read-side decode
  assign c_rd   = bus.chipselect1 & bus.read & (bus.address1 == ADDR_CIPHER);
  assign c_acc  = c_rd & ~ofifo_empty;
  assign c_last = (cbeat == LAST_BEAT);

  assign bus.waitrequest1 = c_rd & ofifo_empty;

  always_comb begin
    cslice = '0;
    for (int i = 0; i < N; i++)
      if (cbeat == BEAT_W'(i)) cslice = ofifo_dout[BLOCK_W-DATA_W*(i+1) +: DATA_W];
  end

  always_comb begin
    status = '0;
    status[ST_AVAIL] = ~ofifo_empty;
    status[ST_IFULL] = ififo_full;
    status[ST_PBUSY] = (pbeat != '0);
    status[ST_KBUSY] = (kbeat != '0);
    status[ST_ICNT_LSB +: ST_CNT_W] = ST_CNT_W'(ififo_count);
    status[ST_OCNT_LSB +: ST_CNT_W] = ST_CNT_W'(ofifo_count);
  end

  always_comb begin
    bus.readdata = '0;
    if (bus.chipselect1 && bus.read) begin
      case (bus.address1)
        ADDR_CIPHER: if (!ofifo_empty) bus.readdata = byte_swap ? bswap(cslice) : cslice;
        ADDR_STATUS: bus.readdata = DATA_W'(status);
        ADDR_BLKCNT: bus.readdata = DATA_W'(blk_cnt);
        default:     bus.readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pbeat      <= '0;
      kbeat      <= '0;
      cbeat      <= '0;
      pt_buf     <= '0;
      key_shadow <= '0;
      key_active <= RESET_KEY;
      whiten     <= 1'b1;
      byte_swap  <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      if (ctl_wr) begin
        whiten    <= bus.writedata[CTRL_WHITEN];
        byte_swap <= bus.writedata[CTRL_SWAP];
      end
      if (soft_clr) begin
        pbeat   <= '0;
        kbeat   <= '0;
        cbeat   <= '0;
        blk_cnt <= '0;
      end else begin
        if (pt_acc) begin
          pt_buf <= pt_asm;
          pbeat  <= pt_last ? '0 : pbeat + BEAT_W'(1);
        end
        if (key_wr) begin
          key_shadow <= key_asm;
          kbeat      <= (kbeat == LAST_BEAT) ? '0 : kbeat + BEAT_W'(1);
          if (kbeat == LAST_BEAT) key_active <= key_asm;
        end
        if (c_acc) begin
          cbeat <= c_last ? '0 : cbeat + BEAT_W'(1);
          if (c_last) blk_cnt <= blk_cnt + 32'd1;
        end
      end
    end
  end

  aes_bridge_fifo #(.WIDTH($bits(core_blk_t)), .DEPTH(IFIFO_DEPTH)) u_ififo (
    .clock (clock),
    .reset (reset),
    .clear (soft_clr),
    .push  (pt_acc & pt_last),
    .pop   (bus.core_ready & ~ififo_empty),
    .din   (ififo_din),
    .dout  (ififo_dout),
    .count (ififo_count),
    .full  (ififo_full),
    .empty (ififo_empty)
  );

  aes_bridge_fifo #(.WIDTH(BLOCK_W), .DEPTH(OFIFO_DEPTH)) u_ofifo (
    .clock (clock),
    .reset (reset),
    .clear (soft_clr),
    .push  (bus.res_valid),
    .pop   (c_acc & c_last),
    .din   (bus.res_text),
    .dout  (ofifo_dout),
    .count (ofifo_count),
    .full  (ofifo_full),
    .empty (ofifo_empty)
  );

  // Head is gated so an empty FIFO presents zeros rather than stale storage
  assign bus.core_valid = ~ififo_empty;
  assign bus.core_text  = ififo_empty ? '0 : ififo_dout.text;
  assign bus.core_key   = ififo_empty ? '0 : ififo_dout.key;
  assign bus.res_ready  = ~ofifo_full;

endmodule

// File: tb/tb_aes_bus_bridge.sv
// Directed bench for aes_bus_bridge: a 32-bit instance for packing, whitening,
// back-pressure and soft clear, and a 64-bit instance for byte-swap.
module tb_aes_bus_bridge;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  aes_bus_bridge_if #(.DATA_W(32)) b32 ();
  aes_bus_bridge_if #(.DATA_W(64)) b64 ();

  aes_bus_bridge #(.DATA_W(32), .IFIFO_DEPTH(4), .OFIFO_DEPTH(4)) u32 (
    .clock (clock), .reset (reset), .bus (b32));
  aes_bus_bridge #(.DATA_W(64), .IFIFO_DEPTH(4), .OFIFO_DEPTH(4)) u64 (
    .clock (clock), .reset (reset), .bus (b64));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr32(input logic [3:0] a, input logic [31:0] d);
    b32.chipselect = 1'b1; b32.write = 1'b1; b32.address = a; b32.writedata = d;
    @(negedge clock);
    for (int i = 0; i < 16 && b32.waitrequest; i++) begin step(); @(negedge clock); end
    if (b32.waitrequest) chk("wr32_stall_timeout", b32.waitrequest, 1'b0);
    step();
    b32.chipselect = 1'b0; b32.write = 1'b0;
  endtask

  task automatic rd32(input logic [3:0] a, input logic [31:0] exp, input string tag);
    b32.chipselect1 = 1'b1; b32.read = 1'b1; b32.address1 = a;
    @(negedge clock);
    chk(tag, b32.readdata, exp);
    step();
    b32.chipselect1 = 1'b0; b32.read = 1'b0;
  endtask

  task automatic wr64(input logic [3:0] a, input logic [63:0] d);
    b64.chipselect = 1'b1; b64.write = 1'b1; b64.address = a; b64.writedata = d;
    step();
    b64.chipselect = 1'b0; b64.write = 1'b0;
  endtask

  task automatic rd64(input logic [3:0] a, input logic [63:0] exp, input string tag);
    b64.chipselect1 = 1'b1; b64.read = 1'b1; b64.address1 = a;
    @(negedge clock);
    chk(tag, b64.readdata, exp);
    step();
    b64.chipselect1 = 1'b0; b64.read = 1'b0;
  endtask

  task automatic wr_block32(input logic [127:0] t);
    for (int j = 0; j < 4; j++) wr32(4'h0, t[127-32*j -: 32]);
  endtask

  // Distinct 128-bit patterns for FIFO ordering checks
  function automatic logic [127:0] blk(input int b);
    return {32'h1000_0000 + 32'(b), 32'h2000_0000 + 32'(b),
            32'h3000_0000 + 32'(b), 32'h4000_0000 + 32'(b)};
  endfunction

  function automatic logic [127:0] rt(input int b);
    return {32'h5000_0000 + 32'(b), 32'h6000_0000 + 32'(b),
            32'h7000_0000 + 32'(b), 32'h8000_0000 + 32'(b)};
  endfunction

  logic [127:0] tmp;

  initial begin
    b32.chipselect = 0; b32.address = '0; b32.write = 0; b32.writedata = '0;
    b32.chipselect1 = 0; b32.address1 = '0; b32.read = 0;
    b32.core_ready = 0; b32.res_valid = 0; b32.res_text = '0;
    b64.chipselect = 0; b64.address = '0; b64.write = 0; b64.writedata = '0;
    b64.chipselect1 = 0; b64.address1 = '0; b64.read = 0;
    b64.core_ready = 0; b64.res_valid = 0; b64.res_text = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_core_valid", b32.core_valid, 1'b0);
    chk("rst_core_text", b32.core_text, '0);
    chk("rst_core_key", b32.core_key, '0);
    chk("rst_res_ready", b32.res_ready, 1'b1);
    chk("rst_waitrequest", b32.waitrequest, 1'b0);
    chk("rst_waitrequest1", b32.waitrequest1, 1'b0);
    chk("rst_readdata", b32.readdata, '0);
    step();
    rd32(4'h8, 32'h0, "rst_status");
    rd32(4'hC, 32'h0, "rst_blkcnt");

    // Key load then plaintext block
    wr32(4'h4, 32'h00010203); wr32(4'h4, 32'h04050607);
    rd32(4'h8, 32'h0000_0008, "status_kbusy");
    wr32(4'h4, 32'h08090a0b); wr32(4'h4, 32'h0c0d0e0f);
    wr32(4'h0, 32'h00112233);
    rd32(4'h8, 32'h0000_0004, "status_pbusy");
    wr32(4'h0, 32'h44556677); wr32(4'h0, 32'h8899aabb); wr32(4'h0, 32'hccddeeff);
    @(negedge clock);
    chk("blk0_core_valid", b32.core_valid, 1'b1);
    chk("blk0_core_text", b32.core_text, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("blk0_core_key", b32.core_key, 128'h000102030405060708090a0b0c0d0e0f);
    step();
    rd32(4'h8, 32'h0000_0100, "status_ififo1");
    b32.core_ready = 1'b1; step(); b32.core_ready = 1'b0;
    @(negedge clock);
    chk("blk0_popped", b32.core_valid, 1'b0);
    step();

    // Result return and cipher unpack
    b32.res_valid = 1'b1; b32.res_text = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    step();
    b32.res_valid = 1'b0;
    rd32(4'h8, 32'h0001_0001, "status_cipher_avail");
    rd32(4'h4, 32'h69c4e0d8, "cipher_w0");
    rd32(4'h4, 32'h6a7b0430, "cipher_w1");
    rd32(4'h4, 32'hd8cdb780, "cipher_w2");
    rd32(4'h4, 32'h70b4c55a, "cipher_w3");
    rd32(4'hC, 32'h1, "blkcnt_1");
    rd32(4'h8, 32'h0, "status_after_read");

    // Unmapped accesses
    wr32(4'hC, 32'hffff_ffff);
    rd32(4'h0, 32'h0, "unmapped_rd");
    rd32(4'h8, 32'h0, "unmapped_wr_ignored");

    // New key takes effect for later blocks
    for (int j = 0; j < 4; j++) wr32(4'h4, 32'hffff_ffff);
    wr_block32('0);
    @(negedge clock);
    chk("keyf_core_text", b32.core_text, {128{1'b1}});
    chk("keyf_core_key", b32.core_key, {128{1'b1}});
    step();
    b32.core_ready = 1'b1; step(); b32.core_ready = 1'b0;
    for (int j = 0; j < 4; j++) wr32(4'h4, 32'h0);

    // IFIFO back-pressure on the final beat of block DEPTH+1
    for (int b = 0; b < 4; b++) wr_block32(blk(b));
    rd32(4'h8, 32'h0000_0402, "status_ififo_full");
    tmp = blk(4);
    for (int j = 0; j < 3; j++) wr32(4'h0, tmp[127-32*j -: 32]);
    b32.chipselect = 1'b1; b32.write = 1'b1; b32.address = 4'h0; b32.writedata = tmp[31:0];
    b32.chipselect1 = 1'b1; b32.read = 1'b1; b32.address1 = 4'h8;
    @(negedge clock);
    chk("wreq_full0", b32.waitrequest, 1'b1);
    chk("status_full_pbusy", b32.readdata, 32'h0000_0406);
    chk("head_stable0", b32.core_text, blk(0));
    step();
    @(negedge clock);
    chk("wreq_full1", b32.waitrequest, 1'b1);
    chk("head_stable1", b32.core_text, blk(0));
    step();
    b32.core_ready = 1'b1;
    @(negedge clock);
    chk("wreq_pop_cycle", b32.waitrequest, 1'b1);
    step();
    b32.core_ready = 1'b0;
    @(negedge clock);
    chk("wreq_released", b32.waitrequest, 1'b0);
    chk("status_room", b32.readdata, 32'h0000_0304);
    step();
    b32.chipselect = 1'b0; b32.write = 1'b0;
    b32.chipselect1 = 1'b0; b32.read = 1'b0;
    rd32(4'h8, 32'h0000_0402, "status_refilled");
    b32.core_ready = 1'b1;
    for (int b = 1; b < 5; b++) begin
      @(negedge clock);
      chk($sformatf("drain_blk%0d", b), b32.core_text, blk(b));
      step();
    end
    b32.core_ready = 1'b0;
    @(negedge clock);
    chk("drain_empty", b32.core_valid, 1'b0);
    step();

    // Cipher read stalls on empty OFIFO without advancing the beat
    b32.chipselect1 = 1'b1; b32.read = 1'b1; b32.address1 = 4'h4;
    @(negedge clock);
    chk("wreq1_empty0", b32.waitrequest1, 1'b1);
    chk("rd_empty_zero", b32.readdata, 32'h0);
    step();
    b32.res_valid = 1'b1; b32.res_text = 128'h11111111_22222222_33333333_44444444;
    @(negedge clock);
    chk("wreq1_empty1", b32.waitrequest1, 1'b1);
    step();
    b32.res_valid = 1'b0;
    tmp = 128'h11111111_22222222_33333333_44444444;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      if (j == 0) chk("wreq1_released", b32.waitrequest1, 1'b0);
      chk($sformatf("stall_cipher_w%0d", j), b32.readdata, tmp[127-32*j -: 32]);
      step();
    end
    b32.chipselect1 = 1'b0; b32.read = 1'b0;
    rd32(4'hC, 32'h2, "blkcnt_2");

    // OFIFO full: res_ready drops and held data does not overwrite
    b32.res_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin b32.res_text = rt(b); step(); end
    b32.res_text = {4{32'hdead_beef}};
    @(negedge clock);
    chk("res_ready_full", b32.res_ready, 1'b0);
    step();
    rd32(4'h8, 32'h0004_0001, "status_ofifo_full");
    b32.res_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      tmp = rt(b);
      for (int j = 0; j < 4; j++)
        rd32(4'h4, tmp[127-32*j -: 32], $sformatf("ofull_b%0d_w%0d", b, j));
    end
    rd32(4'hC, 32'h6, "blkcnt_6");

    // Soft clear with partial beats and data in both FIFOs
    wr_block32(blk(9));
    b32.res_valid = 1'b1; b32.res_text = rt(9); step(); b32.res_valid = 1'b0;
    wr32(4'h0, 32'haaaa_aaaa); wr32(4'h0, 32'hbbbb_bbbb);
    wr32(4'h4, 32'h1234_5678);
    rd32(4'h8, 32'h0001_010d, "status_pre_clear");
    wr32(4'h8, 32'h3);
    rd32(4'h8, 32'h0, "status_post_clear");
    rd32(4'hC, 32'h0, "blkcnt_clear");
    @(negedge clock);
    chk("clear_core_valid", b32.core_valid, 1'b0);
    step();
    wr_block32(blk(7));
    @(negedge clock);
    chk("post_clear_text", b32.core_text, blk(7));
    chk("post_clear_key", b32.core_key, '0);
    step();

    // 64-bit instance: byte-swap on, whitening off
    wr64(4'h8, 64'h4);
    wr64(4'h0, 64'h7766554433221100);
    wr64(4'h0, 64'hffeeddccbbaa9988);
    @(negedge clock);
    chk("w64_core_valid", b64.core_valid, 1'b1);
    chk("w64_core_text", b64.core_text, 128'h00112233445566778899aabbccddeeff);
    chk("w64_core_key", b64.core_key, 128'h000102030405060708090a0b0c0d0e0f);
    step();
    b64.core_ready = 1'b1; step(); b64.core_ready = 1'b0;
    b64.res_valid = 1'b1; b64.res_text = 128'h0123456789abcdef_fedcba9876543210;
    step();
    b64.res_valid = 1'b0;
    rd64(4'h4, 64'hefcdab8967452301, "w64_cipher_w0");
    rd64(4'h4, 64'h1032547698badcfe, "w64_cipher_w1");
    rd64(4'hC, 64'h1, "w64_blkcnt");
    rd64(4'h8, 64'h0, "w64_status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_bus_bridge.md
# aes_bus_bridge

- Parametrised bus-side front end for the AES round pipeline.
- Packs plaintext bus beats into 128-bit blocks and applies initial AddRoundKey whitening with a bus-programmable key.
- Buffers blocks and presents them to the pipeline over a valid/ready stream; buffers returned ciphertext and unpacks it to the read slave.
- Adds configurable bus width and FIFO depths, key loading, byte-swap, status and a block counter.

## Interface
Parameters:
- DATA_W, 32, bus beat width; 32 or 64; N = 128/DATA_W beats per block
- IFIFO_DEPTH, 4, input block FIFO entries; power of 2, 2..128
- OFIFO_DEPTH, 4, output cipher FIFO entries; power of 2, 2..128

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- chipselect  in  1  write-slave select
- address  in  4  write-slave offset: 0x0 plaintext, 0x4 key, 0x8 control
- write  in  1  write strobe
- writedata  in  DATA_W  write data
- waitrequest  out  1  write stall
- chipselect1  in  1  read-slave select
- address1  in  4  read-slave offset: 0x4 cipher, 0x8 status, 0xC block count
- read  in  1  read strobe
- readdata  out  DATA_W  combinational read data; 0 when no mapped read
- waitrequest1  out  1  read stall
- core_valid  out  1  whitened block available to pipeline
- core_ready  in  1  pipeline accepts block
- core_text  out  128  whitened block (IFIFO head)
- core_key  out  128  key snapshot for this block (IFIFO head)
- res_valid  in  1  pipeline result valid
- res_ready  out  1  = ~ofifo_full
- res_text  in  128  ciphertext

## Operation
- Plaintext (0x0): pbeat counter 0..N-1. Beat 0 fills [127:128-DATA_W]; later beats fill successively lower slices.
- On beat N-1 the entry {assembled ^ key_active (if whiten), key_active} is pushed to the IFIFO (256 bits wide). The counter then wraps to 0.
- Key (0x4): kbeat counter, same MSB-first order into key_shadow. On beat N-1, key_active <= completed shadow in the same edge.
  - Blocks already in the IFIFO keep their snapshot key.
  - A plaintext final beat in the same cycle as a key final beat uses the old key.
- Control (0x8): bit0 soft_clear (self-clearing), bit1 whiten (reset 1), bit2 byte_swap (reset 0).
  - byte_swap reverses bytes within each beat on plaintext/key writes and cipher reads.
  - A control write with bit0 = 1 updates bit1 and bit2 in the same edge.
- soft_clear at edge k, taking effect at that edge:
  - Both FIFOs emptied; pbeat, kbeat, cbeat zeroed; block count zeroed.
  - key_active, whiten and byte_swap retained.
  - Writes in the soft_clear cycle to other addresses are discarded.
- Core stream:
  - core_valid = ~ififo_empty; pop on core_valid & core_ready.
  - Push to OFIFO on res_valid & res_ready.
  - core_valid holds, with core_text/core_key stable, until accepted.
- Cipher read (0x4): cbeat counter, MSB-first slices of OFIFO head. Pop on beat N-1. Block count increments on that pop, 32-bit wrap (upper bits zero when DATA_W = 64).
- Status (0x8):
  - [0] cipher available (~ofifo_empty)
  - [1] ififo_full
  - [2] pbeat != 0
  - [3] kbeat != 0
  - [15:8] IFIFO count
  - [23:16] OFIFO count
  - others 0
- Unmapped addresses: writes ignored, readdata 0.

## Timing
- Reset values:
  - core_valid 0, core_text/core_key 0, res_ready 1
  - waitrequest 0, waitrequest1 0, readdata 0
  - key_active 128'h000102030405060708090a0b0c0d0e0f
  - whiten 1, byte_swap 0
  - all counters 0
- waitrequest = plaintext write & pbeat==N-1 & ififo_full. Non-final beats never stall; key and control writes never stall.
- waitrequest1 = cipher read & ofifo_empty. cbeat advances only when not stalled.
- Full/empty flags come from the registered count. A push while full is refused even if a pop occurs in the same cycle. A pop and push at the same edge on a non-full, non-empty FIFO leaves the count unchanged.
- Latencies:
  - Final plaintext beat accepted at edge k → core_valid=1 in cycle k+1.
  - res_valid accepted at edge m → status[0]=1 and cipher readable in cycle m+1.
- Reset mid-block discards partial beats, FIFO contents and any in-flight result.

## Structure
- Package aes_bridge_pkg:
  - register offsets
  - control bit indices
  - status field positions
  - reset key constant
- Sub-module aes_bridge_fifo: parametrised WIDTH/DEPTH synchronous FIFO with count, full and empty outputs. Instantiated as IFIFO (256) and OFIFO (128).
- Top module holds the beat counters, key/control registers, whitening, byte-swap and read mux.

## Test plan
- DATA_W=32, write key 00010203,04050607,08090a0b,0c0d0e0f, then plaintext 00112233,44556677,8899aabb,ccddeeff → core_text=00102030405060708090a0b0c0d0e0f0, core_key=000102030405060708090a0b0c0d0e0f.
- Stub returns res_text 69c4e0d86a7b0430d8cdb78070b4c55a → status[0]=1 next cycle. Four cipher reads return 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a. Block count 1, status[0]=0.
- Hold core_ready=0 and write IFIFO_DEPTH+1 blocks → the last final beat has waitrequest=1 until one core_ready pulse, then is accepted on the next edge.
- Cipher read with OFIFO empty → waitrequest1=1, cbeat unchanged. Hold res_valid with OFIFO full → res_ready=0 and no overwrite.
- Write 2 plaintext beats, then control 0x1 → status[2]=0, FIFOs empty, key unchanged. The next full block packs from beat 0.
- DATA_W=64, byte_swap=1, whiten=0, plaintext 7766554433221100, ffeeddccbbaa9988 → core_text=00112233445566778899aabbccddeeff.
